bus_master_if: RTL

BUS_MASTER_IF -- requirements
Module: bus_master_if

---
 rtl/bus_master_if.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/bus_master_if.sv
// bus_master_if: bridges a level CPU request onto an arbitrated strobe/ready bus.
// Optional BUS_MASTER_TIMEOUT_EN aborts an ACCESS after TIMEOUT_CYC cycles without ready.
module bus_master_if #(
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_rw_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_busy_o,
    output logic              cpu_ack_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_err_o,
    output logic              bus_req_o,
    input  logic              bus_grnt_i,
    output logic              bus_as_o,
    output logic              bus_rw_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_rdy_i
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACCESS,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 2);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
`else
    logic              unused_tmo;
    assign unused_tmo = (TIMEOUT_CYC == 0);
`endif

    // Next-state and datapath; the wait counter is cleared per new access so a retry keeps it.
    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef BUS_MASTER_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef BUS_MASTER_TIMEOUT_EN
                err_d = 1'b0;
`endif
                if (cpu_req_i) begin
                    state_d = REQ;
                    rw_d    = cpu_rw_i;
                    addr_d  = cpu_addr_i;
                    wdata_d = cpu_wdata_i;
`ifdef BUS_MASTER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            REQ: begin
                if (bus_grnt_i) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (bus_rdy_i) begin
                    state_d = DONE;
                    if (rw_q) begin
                        rdata_d = bus_rdata_i;
                    end
`ifdef BUS_MASTER_TIMEOUT_EN
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == TMO) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (!bus_grnt_i) begin
                        state_d = REQ;
                    end
                end
`else
                end else if (!bus_grnt_i) begin
                    state_d = REQ;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched access registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef BUS_MASTER_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef BUS_MASTER_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        cpu_busy_o  = (state_q != IDLE);
        cpu_ack_o   = (state_q == DONE);
        cpu_rdata_o = rdata_q;
`ifdef BUS_MASTER_TIMEOUT_EN
        cpu_err_o   = err_q && (state_q == DONE);
`else
        cpu_err_o   = 1'b0;
`endif
        bus_req_o   = (state_q == REQ) || (state_q == ACCESS);
        bus_as_o    = (state_q == ACCESS);
        bus_rw_o    = bus_as_o && rw_q;
        bus_addr_o  = bus_as_o ? addr_q : '0;
        bus_wdata_o = bus_as_o ? wdata_q : '0;
    end

endmodule
